// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flop-based FIFO family.
// No logic; pure declarations.
package fifo_pkg;

    typedef enum logic {
        FIFO_DROP      = 1'b0,
        FIFO_OVERWRITE = 1'b1
    } fifo_mode_e;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer; advances on inc, wraps DEPTH-1 -> 0.
// Registered output, 1-cycle update; no backpressure (caller gates inc).
module fifo_ptr #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_flops_cfg.sv
// Flop-array synchronous FIFO, first-word fall-through, occupancy count and sticky errors.
// 1-cycle write-to-read; no ready/valid: pushes when full drop or overwrite per MODE, pops when empty are ignored.
module fifo_flops_cfg
    import fifo_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter int         BITS     = 16,
    parameter int         AF_LEVEL = DEPTH - 2,
    parameter int         AE_LEVEL = 2,
    parameter fifo_mode_e MODE     = FIFO_DROP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BITS-1:0]              Din,
    input  logic                         push,
    input  logic                         pop,
    output logic [BITS-1:0]              Dout,
    output logic                         pndng,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flops_cfg: DEPTH must be >= 2");
    end
    if (BITS < 1) begin : g_bad_bits
        $error("fifo_flops_cfg: BITS must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flops_cfg: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flops_cfg: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            do_pop;
    logic            do_push;
    logic            ovw;
    logic            ovf_set;
    logic            unf_set;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full FIFO is accepted only if a pop frees a slot or the oldest entry is sacrificed.
    assign ovf_set = push & full & ~pop;
    assign unf_set = pop & empty;
    assign ovw     = ovf_set & (MODE == FIFO_OVERWRITE);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop | ovw);

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_pop | ovw),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push && !do_pop && !full) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            // A new error in the same cycle as err_clr wins.
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    assign Dout         = empty ? '0 : mem[rd_ptr];
    assign pndng        = ~empty;
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_flops_cfg.sv
// Drives a DROP and an OVERWRITE instance with shared stimulus and compares both
// against queue-based reference models every cycle.
module tb_fifo_flops_cfg;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int BITS  = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] Din;
    logic            push;
    logic            pop;
    logic            err_clr;

    logic [BITS-1:0] dout_o [2];
    logic            pndng_o [2];
    logic            full_o [2];
    logic            af_o [2];
    logic            ae_o [2];
    logic [4:0]      cnt_o [2];
    logic            ovf_o [2];
    logic            unf_o [2];

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] mq0 [$];
    logic [BITS-1:0] mq1 [$];
    bit              m_ovf [2];
    bit              m_unf [2];

    always #5 clk = ~clk;

    fifo_flops_cfg #(.DEPTH(DEPTH), .BITS(BITS), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_DROP)) u_drop (
        .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop),
        .Dout(dout_o[0]), .pndng(pndng_o[0]), .full(full_o[0]),
        .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(cnt_o[0]),
        .err_clr(err_clr), .overflow(ovf_o[0]), .underflow(unf_o[0])
    );

    fifo_flops_cfg #(.DEPTH(DEPTH), .BITS(BITS), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_OVERWRITE)) u_ovw (
        .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop),
        .Dout(dout_o[1]), .pndng(pndng_o[1]), .full(full_o[1]),
        .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(cnt_o[1]),
        .err_clr(err_clr), .overflow(ovf_o[1]), .underflow(unf_o[1])
    );

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s mode%0d at %0t: observed=%0h expected=%0h", tag, m, $time, obs, exp);
        end
    endtask

    // Behavioural model: a FIFO is an ordered list of at most DEPTH words.
    task automatic model_upd(input int m);
        logic [BITS-1:0] q [$];
        bit was_empty, was_full;
        if (m == 0) q = mq0; else q = mq1;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (pop && !was_empty) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(Din);
            else if (m == 1) begin
                void'(q.pop_front());
                q.push_back(Din);
            end
        end
        m_ovf[m] = (push && was_full && !pop) || (m_ovf[m] && !err_clr);
        m_unf[m] = (pop && was_empty) || (m_unf[m] && !err_clr);
        if (m == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int m = 0; m < 2; m++) begin
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [BITS-1:0] q [$];
        int n;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) q = mq0; else q = mq1;
            n = q.size();
            chk("count", m, 32'(cnt_o[m]), 32'(n));
            chk("dout", m, 32'(dout_o[m]), (n > 0) ? 32'(q[0]) : 32'd0);
            chk("pndng", m, 32'(pndng_o[m]), 32'(n > 0));
            chk("full", m, 32'(full_o[m]), 32'(n == DEPTH));
            chk("almost_full", m, 32'(af_o[m]), 32'(n >= AFL));
            chk("almost_empty", m, 32'(ae_o[m]), 32'(n <= AEL));
            chk("overflow", m, 32'(ovf_o[m]), 32'(m_ovf[m]));
            chk("underflow", m, 32'(unf_o[m]), 32'(m_unf[m]));
        end
    endtask

    task automatic step(input logic p, input logic r, input logic [BITS-1:0] d, input logic c);
        push = p; pop = r; Din = d; err_clr = c;
        @(posedge clk);
        model_upd(0);
        model_upd(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        push = 0; pop = 0; err_clr = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; push = 0; pop = 0; err_clr = 0; Din = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Fill with 0..15 then drain.
        for (int i = 0; i < 16; i++) step(1, 0, 16'(i), 0);
        for (int i = 0; i < 16; i++) step(0, 1, 16'h0, 0);

        // 40 pushes: DROP keeps 0..15, OVERWRITE keeps 24..39; then clear errors.
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 0, 16'(i), 0);
        for (int i = 0; i < 16; i++) step(0, 1, 16'h0, 0);
        step(0, 0, 16'h0, 1);

        // Underflow, then err_clr colliding with a fresh underflow.
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 1, 16'h0, 0);
        step(0, 1, 16'h0, 1);
        step(0, 0, 16'h0, 1);

        // Simultaneous push/pop at count 8, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 16'(16'h100 + i), 0);
        for (int i = 0; i < 17; i++) step(1, 1, 16'($urandom), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0, 0);

        // Push+pop on empty: push wins, underflow flags.
        do_reset();
        step(1, 1, 16'hBEEF, 0);
        step(1, 1, 16'h1234, 0);
        step(0, 1, 16'h0, 0);

        // Full + push + pop in both modes.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 16'(16'hA00 + i), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 16'(16'hB00 + i), 0);

        // Thresholds on the way up, then asynchronous reset mid-cycle at count 9.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 0, 16'(16'hC00 + i), 0);
        push = 0; pop = 0;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        #3;
        rst = 1'b1;

        // Random traffic with biased push/pop mixes.
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 250) % 3;
            step(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
